ecc_secded_pipe: RTL and testbench
==================================

Name: ecc_secded_pipe

Overview:
- Parametrised successor to the single-error fix stage: a pipelined SECDED (extended Hamming) decoder for 8/16/32-bit codewords.
- Computes syndrome and overall parity internally, classifies the error count, and corrects single-bit errors.
- Carries words through a 2-stage valid/ready pipeline with full backpressure.
- Sits between the APB/AMBA register block and the decoded-data output path.

Parameters:
- AMBA_WORD, 32, maximum codeword width; must be a power of two and at least 8.
- SYN_W, $clog2(AMBA_WORD), syndrome width.
- CNT_W, 16, width of the error statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_mode  in  2  codeword width: 00=8, 01=16, 10=32, 11=reserved.
- in_data  in  AMBA_WORD  received codeword, LSB-aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  AMBA_WORD  corrected codeword; bits at and above N are zero.
- out_nof  out  2  error class: 00 none, 01 single (corrected), 10 double (uncorrectable), 11 illegal mode.
- out_syndrome  out  SYN_W  computed syndrome.
- cnt_clr  in  1  synchronous clear of the statistics counters (ECC_STATS_EN only).
- corr_cnt  out  CNT_W  count of corrected words (ECC_STATS_EN only).
- uncorr_cnt  out  CNT_W  count of uncorrectable words (ECC_STATS_EN only).

Behaviour:
- Reset: all outputs 0; both stage valids 0; counters 0. Reset mid-operation discards words in flight; in_ready=1 on the first cycle after release.
- N = 8/16/32 per mode. Mask: d = in_data with bits [AMBA_WORD-1:N] forced to 0.
- Syndrome: S = XOR of index j over all set bits d[j], 1<=j<N. Bit 0 is the overall parity bit.
- Parity: P = XOR of d[N-1:0].
- Classification:
  - P=0, S=0 -> nof 00, data unchanged.
  - P=1 -> nof 01, flip d[S]; S=0 flips bit 0.
  - P=0, S!=0 -> nof 10, data passed unmodified.
  - Mode 11 -> nof 11, in_data passed unmasked and uncorrected, S reported as computed over 32 bits.
- Stage 1 registers d, S, P and mode on an input handshake (in_valid & in_ready). Stage 2 registers out_data, out_nof and out_syndrome.
- Latency: 2 cycles from input handshake to out_valid when there is no backpressure. Throughput: 1 word per cycle.
- Advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready; no skid buffer).
- Stall: out_valid, out_data, out_nof and out_syndrome stay stable while out_valid & !out_ready. No word is dropped or duplicated, and order is preserved.
- Simultaneous input and output handshake on a full pipe: both stages shift in the same cycle.

Optional Feature:
- Macro: ECC_STATS_EN.
- When defined: corr_cnt increments on each output handshake with nof=01; uncorr_cnt increments on nof=10 or 11. Both saturate at all-ones. cnt_clr has priority over an increment in the same cycle.
- When undefined: cnt_clr is ignored, corr_cnt and uncorr_cnt are tied to 0, and no counter flops are generated.

Decomposition:
- Shared package ecc_pkg holds:
  - mode encodings MODE_8, MODE_16, MODE_32, MODE_RSVD;
  - NOF_NONE, NOF_SINGLE, NOF_DOUBLE, NOF_ILLEGAL;
  - function cw_len(mode) returning N.
- One sub-module: ecc_syndrome_calc, combinational, producing masked data, S and P. It is reused by the encoder's self-check.

Test Plan:
- Mode 00, in_data=0x69 -> 2 cycles later out_data=0x69, nof=00, syndrome=0.
- Mode 00, single-bit errors:
  - in_data=0x49 -> out_data=0x69, nof=01, syndrome=5.
  - in_data=0x68 -> out_data=0x69, nof=01, syndrome=0.
- Mode 00 double error and masking:
  - in_data=0x09 -> out_data=0x09, nof=10, syndrome=3.
  - in_data=0xFFFFFF69 -> out_data=0x00000069, nof=00.
- Mode 10 and reserved mode:
  - in_data=0x80000000 -> out_data=0x0, nof=01, syndrome=31.
  - Mode 11, in_data=0x1234 -> out_data=0x1234, nof=11.
- Backpressure: push 4 words back-to-back with out_ready=0 for 5 cycles -> in_ready falls after 2 accepted; outputs stay stable; releasing out_ready yields all words in order, one per cycle.
- ECC_STATS_EN with CNT_W=2:
  - 5 single-error words -> corr_cnt saturates at 3.
  - cnt_clr together with a counted handshake -> corr_cnt=0.
  - Assert rst mid-stream -> out_valid=0 immediately, counters 0.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared encodings and codeword-length helper for the SECDED decode path.
package ecc_pkg;

  typedef enum logic [1:0] {
    MODE_8    = 2'b00,
    MODE_16   = 2'b01,
    MODE_32   = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    NOF_NONE    = 2'b00,
    NOF_SINGLE  = 2'b01,
    NOF_DOUBLE  = 2'b10,
    NOF_ILLEGAL = 2'b11
  } nof_e;

  // Reserved mode spans the full 32 bits so its syndrome covers the whole word.
  function automatic int cw_len(input logic [1:0] mode);
    case (mode)
      MODE_8:  return 8;
      MODE_16: return 16;
      default: return 32;
    endcase
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational masking, syndrome (XOR of set-bit indices) and overall parity.
module ecc_syndrome_calc
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int SYN_W     = $clog2(AMBA_WORD)
) (
  input  logic [AMBA_WORD-1:0] i_data,
  input  logic [1:0]           i_mode,
  output logic [AMBA_WORD-1:0] o_data,
  output logic [SYN_W-1:0]     o_syn,
  output logic                 o_par
);

  int w_len;
  assign w_len = cw_len(i_mode);

  always_comb begin
    o_data = '0;
    o_syn  = '0;
    for (int j = 0; j < AMBA_WORD; j++) begin
      if (j < w_len) o_data[j] = i_data[j];
    end
    for (int j = 1; j < AMBA_WORD; j++) begin
      if (o_data[j]) o_syn = o_syn ^ SYN_W'(j);
    end
    o_par = ^o_data;
  end

endmodule

// File: rtl/ecc_secded_pipe.sv
// Two-stage valid/ready SECDED decoder for 8/16/32-bit codewords.
// Optional error statistics counters are built when ECC_STATS_EN is defined.
module ecc_secded_pipe
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int SYN_W     = $clog2(AMBA_WORD),
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_mode,
  input  logic [AMBA_WORD-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [AMBA_WORD-1:0] out_data,
  output logic [1:0]           out_nof,
  output logic [SYN_W-1:0]     out_syndrome,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     corr_cnt,
  output logic [CNT_W-1:0]     uncorr_cnt
);

  logic [AMBA_WORD-1:0] w_mask_data;
  logic [SYN_W-1:0]     w_syn;
  logic                 w_par;

  logic                 r_s1_valid;
  logic [AMBA_WORD-1:0] r_s1_data;
  logic [SYN_W-1:0]     r_s1_syn;
  logic                 r_s1_par;
  logic [1:0]           r_s1_mode;

  logic                 r_s2_valid;
  logic [AMBA_WORD-1:0] r_out_data;
  logic [1:0]           r_out_nof;
  logic [SYN_W-1:0]     r_out_syn;

  logic                 w_s2_adv;
  logic                 w_s1_adv;
  logic [AMBA_WORD-1:0] w_nxt_data;
  logic [1:0]           w_nxt_nof;

  ecc_syndrome_calc #(
    .AMBA_WORD(AMBA_WORD),
    .SYN_W    (SYN_W)
  ) u_syn (
    .i_data(in_data),
    .i_mode(in_mode),
    .o_data(w_mask_data),
    .o_syn (w_syn),
    .o_par (w_par)
  );

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_comb begin
    w_nxt_data = r_s1_data;
    w_nxt_nof  = NOF_NONE;
    if (r_s1_mode == MODE_RSVD) begin
      w_nxt_nof = NOF_ILLEGAL;
    end else if (r_s1_par) begin
      // Odd parity means one flipped bit; syndrome 0 points at the parity bit itself.
      w_nxt_nof  = NOF_SINGLE;
      w_nxt_data = r_s1_data ^ (AMBA_WORD'(1) << r_s1_syn);
    end else if (r_s1_syn != '0) begin
      w_nxt_nof = NOF_DOUBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
      r_s1_mode  <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data <= w_mask_data;
        r_s1_syn  <= w_syn;
        r_s1_par  <= w_par;
        r_s1_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_out_data <= '0;
      r_out_nof  <= '0;
      r_out_syn  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_nxt_data;
        r_out_nof  <= w_nxt_nof;
        r_out_syn  <= r_s1_syn;
      end
    end
  end

  assign out_valid    = r_s2_valid;
  assign out_data     = r_out_data;
  assign out_nof      = r_out_nof;
  assign out_syndrome = r_out_syn;

`ifdef ECC_STATS_EN
  logic             w_out_hs;
  logic [CNT_W-1:0] r_corr_cnt;
  logic [CNT_W-1:0] r_uncorr_cnt;

  assign w_out_hs = r_s2_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (cnt_clr) begin
      r_corr_cnt   <= '0;
      r_uncorr_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_out_nof == NOF_SINGLE && r_corr_cnt != '1)
        r_corr_cnt <= r_corr_cnt + CNT_W'(1);
      if ((r_out_nof == NOF_DOUBLE || r_out_nof == NOF_ILLEGAL) && r_uncorr_cnt != '1)
        r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
    end
  end

  assign corr_cnt   = r_corr_cnt;
  assign uncorr_cnt = r_uncorr_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = cnt_clr;
  assign corr_cnt     = '0;
  assign uncorr_cnt   = '0;
`endif

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// Scoreboard bench for ecc_secded_pipe: directed vectors, backpressure, random codewords.
module tb_ecc_secded_pipe;

  localparam int AW  = 32;
  localparam int SW  = 5;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_mode = 2'b00;
  logic [AW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [1:0]    out_nof;
  logic [SW-1:0] out_syndrome;
  logic          cnt_clr = 1'b0;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  logic or_rand = 1'b0;
  logic or_val = 1'b1;
  logic rnd_ready = 1'b1;
  assign out_ready = or_rand ? rnd_ready : or_val;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  nof;
    logic [4:0]  syn;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   m_corr = 0;
  int   m_unc  = 0;
  logic prev_stall = 1'b0;
  logic [31:0] s_data;
  logic [1:0]  s_nof;
  logic [4:0]  s_syn;

  ecc_secded_pipe #(.AMBA_WORD(AW), .SYN_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nof(out_nof), .out_syndrome(out_syndrome),
    .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [4:0] synd(input logic [31:0] x);
    logic [4:0] s = '0;
    for (int j = 1; j < 32; j++) if (x[j]) s = s ^ 5'(j);
    return s;
  endfunction

  // Build a clean codeword, then inject 0/1/2 errors; expectation follows from construction.
  task automatic gen(output logic [1:0] m, output logic [31:0] d, output exp_t e);
    int n, nerr, e1, e2;
    logic [31:0] w, c, hi;
    logic [4:0]  s;
    if ($urandom_range(0, 7) == 0) begin
      m = 2'b11;
      d = $urandom;
      e = '{d, 2'd3, synd(d)};
      return;
    end
    m = 2'($urandom_range(0, 2));
    n = 8 << m;
    w = $urandom;
    hi = '0;
    if (n < 32) begin
      w  = w & ((32'h1 << n) - 1);
      hi = $urandom & ~((32'h1 << n) - 1);
    end
    s = synd(w);
    for (int k = 0; k < 5; k++) if (s[k]) w = w ^ (32'h1 << (1 << k));
    if (^w) w[0] = ~w[0];
    nerr = $urandom_range(0, 2);
    e1 = $urandom_range(0, n - 1);
    e2 = (e1 + $urandom_range(1, n - 1)) % n;
    c = w;
    if (nerr >= 1) c[e1] = ~c[e1];
    if (nerr == 2) c[e2] = ~c[e2];
    case (nerr)
      0:       e = '{w, 2'd0, 5'd0};
      1:       e = '{w, 2'd1, 5'(e1)};
      default: e = '{c, 2'd2, 5'(e1 ^ e2)};
    endcase
    d = c | hi;
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] d, input exp_t e);
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      errors++;
      checks++;
      $display("FAIL send_timeout: got no in_ready expected accept of 0x%0h", d);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: scoreboard pop, stall stability, statistics model.
  initial begin
    exp_t e;
    logic hs;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_corr = 0;
        m_unc = 0;
        prev_stall = 1'b0;
      end else begin
        chk("corr_cnt", 32'(corr_cnt), m_corr);
        chk("uncorr_cnt", 32'(uncorr_cnt), m_unc);
        if (prev_stall) begin
          chk("stall_valid", 32'(out_valid), 1);
          chk("stall_data", out_data, s_data);
          chk("stall_nof", 32'(out_nof), 32'(s_nof));
          chk("stall_syn", 32'(out_syndrome), 32'(s_syn));
        end
        hs = out_valid && out_ready;
        if (hs) begin
          if (exp_q.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL unexpected_out: got data 0x%0h expected no output", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_nof", 32'(out_nof), 32'(e.nof));
            chk("out_syndrome", 32'(out_syndrome), 32'(e.syn));
`ifdef ECC_STATS_EN
            if (!cnt_clr) begin
              if (e.nof == 2'd1 && m_corr < SAT) m_corr++;
              if (e.nof >= 2'd2 && m_unc < SAT) m_unc++;
            end
`endif
          end
        end
`ifdef ECC_STATS_EN
        if (cnt_clr) begin
          m_corr = 0;
          m_unc = 0;
        end
`endif
        prev_stall = out_valid && !out_ready;
        s_data = out_data;
        s_nof  = out_nof;
        s_syn  = out_syndrome;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] d;
    exp_t        e;
    logic        seen;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_nof", 32'(out_nof), 0);
    chk("rst_corr", 32'(corr_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Latency: out_valid appears two cycles after the word is presented.
    send(2'b00, 32'h69, '{32'h69, 2'd0, 5'd0});
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 1);
    @(posedge clk);
    #1;

    send(2'b00, 32'h49, '{32'h69, 2'd1, 5'd5});
    send(2'b00, 32'h68, '{32'h69, 2'd1, 5'd0});
    send(2'b00, 32'h09, '{32'h09, 2'd2, 5'd3});
    send(2'b00, 32'hFFFF_FF69, '{32'h69, 2'd0, 5'd0});
    send(2'b10, 32'h8000_0000, '{32'h0, 2'd1, 5'd31});
    send(2'b11, 32'h1234, '{32'h1234, 2'd3, 5'd6});
    idle(5);

    // Backpressure: two words fill the pipe, then the third must wait.
    or_val = 1'b0;
    send(2'b00, 32'h49, '{32'h69, 2'd1, 5'd5});
    send(2'b00, 32'h68, '{32'h69, 2'd1, 5'd0});
    in_valid = 1'b1;
    in_data  = 32'h6B;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #1 or_val = 1'b1;
    send(2'b00, 32'h6B, '{32'h69, 2'd1, 5'd1});
    send(2'b00, 32'h29, '{32'h69, 2'd1, 5'd6});
    idle(5);
    chk("corr_saturated", 32'(corr_cnt), `ifdef ECC_STATS_EN 32'(SAT) `else 32'd0 `endif);

    // Clear coinciding with a counted handshake: clear wins.
    or_val = 1'b0;
    send(2'b00, 32'h49, '{32'h69, 2'd1, 5'd5});
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("clr_wait_valid", 32'(seen), 1);
    @(posedge clk);
    #1;
    cnt_clr = 1'b1;
    or_val  = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    chk("clr_corr", 32'(corr_cnt), 0);
    idle(3);

    // Random codewords under random backpressure.
    or_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      gen(m, d, e);
      send(m, d, e);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    or_rand = 1'b0;
    or_val = 1'b1;
    idle(10);
    chk("drain_random", exp_q.size(), 0);

    // Reset mid-stream with the pipe full.
    or_val = 1'b0;
    send(2'b00, 32'h09, '{32'h09, 2'd2, 5'd3});
    send(2'b00, 32'h49, '{32'h69, 2'd1, 5'd5});
    #3 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_corr", 32'(corr_cnt), 0);
    chk("midrst_uncorr", 32'(uncorr_cnt), 0);
    exp_q.delete();
    in_valid = 1'b0;
    or_val = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 1);
    send(2'b01, 32'h0000_0069, '{32'h69, 2'd0, 5'd0});
    idle(6);
    chk("drain_final", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
